// File: rtl/risc_ctrl_pkg.sv
// rtl/risc_ctrl_pkg.sv - shared states, opcode map and control encodings for the multicycle sequencer
package risc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h01;
    localparam logic [5:0] OP_SUBI  = 6'h02;
    localparam logic [5:0] OP_ANDI  = 6'h03;
    localparam logic [5:0] OP_XORI  = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h08;
    localparam logic [5:0] OP_SW    = 6'h09;
    localparam logic [5:0] OP_BR    = 6'h10;
    localparam logic [5:0] OP_BNS   = 6'h16;
    localparam logic [5:0] OP_JAL   = 6'h18;
    localparam logic [5:0] OP_JR    = 6'h19;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h00;
    localparam logic [5:0] FN_XOR = 6'h03;

    localparam logic [1:0] RD_RS  = 2'b00;
    localparam logic [1:0] RD_RT  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] PC_INCR = 2'b00;
    localparam logic [1:0] PC_JTA  = 2'b01;
    localparam logic [1:0] PC_REG  = 2'b10;

    localparam logic [1:0] RID_MEM    = 2'b00;
    localparam logic [1:0] RID_ALU    = 2'b01;
    localparam logic [1:0] RID_INCRPC = 2'b10;
    localparam logic [1:0] RID_SHIFT  = 2'b11;

    localparam logic [2:0] BR_ALWAYS = 3'b000;
    localparam logic [2:0] BR_Z      = 3'b001;
    localparam logic [2:0] BR_NZ     = 3'b010;
    localparam logic [2:0] BR_CY     = 3'b011;
    localparam logic [2:0] BR_NCY    = 3'b100;
    localparam logic [2:0] BR_S      = 3'b101;
    localparam logic [2:0] BR_NS     = 3'b110;

    typedef struct packed {
        logic       pc_reset;
        logic       pc_write;
        logic       flag_en;
        logic [1:0] reg_dst;
        logic       write_en;
        logic       alu_imm;
        logic       alu_fn;
        logic       logic_fn;
        logic       fn_class;
        logic       reg_imm;
        logic       arith_logic;
        logic       left_right;
        logic       d_write;
        logic       d_read;
        logic [2:0] br_type;
        logic [1:0] pc_sel;
        logic [1:0] reg_in_data;
        logic       halted;
    } ctrl_t;

    function automatic logic is_shift_fn(input logic [5:0] fn);
        return fn[5:3] == 3'b010;
    endfunction

    function automatic logic is_alu_imm_op(input logic [5:0] op);
        return (op >= OP_ADDI) && (op <= OP_XORI);
    endfunction

    // Branch class covers unconditional and conditional branches plus jal/jr.
    function automatic logic is_branch_op(input logic [5:0] op);
        return ((op >= OP_BR) && (op <= OP_BNS)) || (op == OP_JAL) || (op == OP_JR);
    endfunction

    function automatic logic op_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_RTYPE)
            return (fn <= FN_XOR) || is_shift_fn(fn);
        return is_alu_imm_op(op) || (op == OP_LW) || (op == OP_SW)
            || is_branch_op(op) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational control vector from state and latched instruction, plus legality of raw op/fn
module ctrl_decoder
    import risc_ctrl_pkg::*;
(
    input  state_t      state_i,
    input  logic [5:0]  ir_op_i,
    input  logic [5:0]  ir_fn_i,
    input  logic [5:0]  op_i,
    input  logic [5:0]  fn_i,
    output ctrl_t       ctrl_o,
    output logic        legal_o
);

    logic       is_r;
    logic       is_shift;
    logic       is_imm;
    logic       is_lw;
    logic       is_sw;
    logic       is_alu;
    logic       in_instr;
    logic [5:0] op_m1;
    logic [1:0] alu_code;

    assign legal_o  = op_legal(op_i, fn_i);
    assign is_r     = (ir_op_i == OP_RTYPE);
    assign is_shift = is_r && is_shift_fn(ir_fn_i);
    assign is_imm   = is_alu_imm_op(ir_op_i);
    assign is_lw    = (ir_op_i == OP_LW);
    assign is_sw    = (ir_op_i == OP_SW);
    assign is_alu   = (is_r && !is_shift) || is_imm;
    assign in_instr = (state_i == ST_EXEC) || (state_i == ST_MEM) || (state_i == ST_WB);
    assign op_m1    = ir_op_i - 6'd1;

    // Immediate opcodes 1..4 map onto the R-type fn codes 0..3; lw/sw use add.
    assign alu_code = is_imm ? op_m1[1:0] : (is_alu ? ir_fn_i[1:0] : 2'b00);

    always_comb begin
        ctrl_o = '0;
        if (in_instr) begin
            if (is_alu || is_lw || is_sw) begin
                ctrl_o.alu_imm  = is_imm || is_lw || is_sw;
                ctrl_o.fn_class = alu_code[1];
                ctrl_o.alu_fn   = !alu_code[1] && alu_code[0];
                ctrl_o.logic_fn = alu_code[1] && alu_code[0];
            end
            if (is_shift) begin
                ctrl_o.reg_imm     = ir_fn_i[2];
                ctrl_o.arith_logic = ir_fn_i[1];
                ctrl_o.left_right  = ir_fn_i[0];
            end
        end
        case (state_i)
            ST_RESET: begin
                ctrl_o.pc_reset = 1'b1;
                ctrl_o.pc_write = 1'b1;
            end
            ST_EXEC: begin
                ctrl_o.flag_en = is_alu;
                if (is_branch_op(ir_op_i)) begin
                    ctrl_o.pc_write = 1'b1;
                    if (ir_op_i == OP_JR) begin
                        ctrl_o.pc_sel = PC_REG;
                    end else if (ir_op_i == OP_JAL) begin
                        ctrl_o.pc_sel      = PC_JTA;
                        ctrl_o.reg_dst     = RD_R31;
                        ctrl_o.reg_in_data = RID_INCRPC;
                        ctrl_o.write_en    = 1'b1;
                    end else begin
                        ctrl_o.pc_sel  = PC_JTA;
                        ctrl_o.br_type = ir_op_i[2:0];
                    end
                end
            end
            ST_MEM: begin
                ctrl_o.d_read   = is_lw;
                ctrl_o.d_write  = is_sw;
                ctrl_o.pc_write = is_sw;
            end
            ST_WB: begin
                ctrl_o.write_en = 1'b1;
                ctrl_o.pc_write = 1'b1;
                if (is_lw) begin
                    ctrl_o.reg_dst     = RD_RT;
                    ctrl_o.reg_in_data = RID_MEM;
                end else begin
                    ctrl_o.reg_dst     = RD_RS;
                    ctrl_o.reg_in_data = is_shift ? RID_SHIFT : RID_ALU;
                end
            end
            ST_HALT: ctrl_o.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle sequencer FSM, instruction latch and retired counter
module multicycle_control_unit
    import risc_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          op,
    input  logic [5:0]          fn,
    output logic                PCReset,
    output logic                pc_write,
    output logic                flag_en,
    output logic [1:0]          regDst,
    output logic                writeEn,
    output logic                ALUimm,
    output logic                Alufn,
    output logic                logicfn,
    output logic                fnClass,
    output logic                RegImm,
    output logic                AL,
    output logic                leftright,
    output logic                DWrite,
    output logic                DRead,
    output logic [2:0]          brType,
    output logic [1:0]          PCSel,
    output logic [1:0]          RegInData,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [RETIRE_W-1:0] RET_ONE = RETIRE_W'(1);

    state_t                state_q;
    state_t                state_d;
    logic [5:0]            ir_op_q;
    logic [5:0]            ir_fn_q;
    logic                  illegal_q;
    logic [RETIRE_W-1:0]   retired_q;
    ctrl_t                 ctrl;
    logic                  legal;

    ctrl_decoder u_dec (
        .state_i (state_q),
        .ir_op_i (ir_op_q),
        .ir_fn_i (ir_fn_q),
        .op_i    (op),
        .fn_i    (fn),
        .ctrl_o  (ctrl),
        .legal_o (legal)
    );

    always_comb begin
        state_d = ST_RESET;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = (!legal || op == OP_HALT) ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (ir_op_q == OP_LW || ir_op_q == OP_SW)
                    state_d = ST_MEM;
                else if (is_branch_op(ir_op_q))
                    state_d = ST_FETCH;
                else
                    state_d = ST_WB;
            end
            ST_MEM:    state_d = (ir_op_q == OP_LW) ? ST_WB : ST_FETCH;
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            ir_op_q   <= '0;
            ir_fn_q   <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                ir_op_q <= op;
                ir_fn_q <= fn;
                if (!legal)
                    illegal_q <= 1'b1;
            end
            // The PC load ending each instruction is what counts it as retired.
            if (ctrl.pc_write && state_q != ST_RESET)
                retired_q <= retired_q + RET_ONE;
        end
    end

    assign PCReset   = ctrl.pc_reset;
    assign pc_write  = ctrl.pc_write;
    assign flag_en   = ctrl.flag_en;
    assign regDst    = ctrl.reg_dst;
    assign writeEn   = ctrl.write_en;
    assign ALUimm    = ctrl.alu_imm;
    assign Alufn     = ctrl.alu_fn;
    assign logicfn   = ctrl.logic_fn;
    assign fnClass   = ctrl.fn_class;
    assign RegImm    = ctrl.reg_imm;
    assign AL        = ctrl.arith_logic;
    assign leftright = ctrl.left_right;
    assign DWrite    = ctrl.d_write;
    assign DRead     = ctrl.d_read;
    assign brType    = ctrl.br_type;
    assign PCSel     = ctrl.pc_sel;
    assign RegInData = ctrl.reg_in_data;
    assign halted    = ctrl.halted;
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer for the RISC datapath.
- Takes op/fn from the datapath and steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives every datapath control input, plus two enables added to the datapath: pc_write on the PC register and flag_en on the negedge flag registers.
- Sits beside the datapath in the processor top level.

Parameters:
RETIRE_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock; all state changes on posedge
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
op  in  6  instr[31:26] from datapath
fn  in  6  instr[5:0] from datapath
PCReset  out  1  forces next PC to 0
pc_write  out  1  PC register load enable
flag_en  out  1  enables datapath flag registers
regDst  out  2  write address select: 00 rs, 01 rt, 10 r31
writeEn  out  1  register file write
ALUimm, Alufn, logicfn, fnClass  out  1 each  ALU controls
RegImm, AL, leftright  out  1 each  shifter controls
DWrite, DRead  out  1 each  data cache write/read
brType  out  3  branch condition to NextAddr
PCSel  out  2  00 incr, 01 jta/branch, 10 register
RegInData  out  2  00 mem, 01 ALU, 10 IncrPC, 11 shifter
halted  out  1  core stopped
illegal  out  1  stopped on undecodable instruction
retired  out  RETIRE_W  instructions completed, wraps

Behaviour:
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Async rst_n low: state=RESET, ir_op/ir_fn=0, retired=0, illegal=0.
- Reset mid-instruction aborts with no register write or memory write.
- Outputs are Moore, decoded from state plus latched ir_op/ir_fn. Any output not named for a state is 0.
- RESET: PCReset=1, pc_write=1 (PC loads 0). Goes to FETCH on the first posedge after rst_n rises.
- FETCH: all outputs 0 while the instruction BRAM reads. Goes to DECODE.
- DECODE: latch ir_op<=op, ir_fn<=fn.
  - Unknown op/fn: go to HALT with illegal=1.
  - Otherwise go to EXEC.
- ALU/shifter controls stay driven from EXEC to instruction end. flag_en=1 in EXEC only, for ALU-class ops.
- Opcode map, dest register and path:
  - 0x00 R-type, dest rs, EXEC->WB. RegInData=01 unless shift.
    - fn 0x00 add: fnClass=0, Alufn=0.
    - fn 0x01 sub: fnClass=0, Alufn=1.
    - fn 0x02 and: fnClass=1, logicfn=0.
    - fn 0x03 xor: fnClass=1, logicfn=1.
    - fn 0x10-0x17 shift: RegImm=fn[2], AL=fn[1], leftright=fn[0], RegInData=11, flag_en=0.
  - 0x01 addi, 0x02 subi, 0x03 andi, 0x04 xori: same ALU codes with ALUimm=1. Dest rs, RegInData=01, EXEC->WB.
  - 0x08 lw: ALUimm=1, add. EXEC->MEM (DRead=1)->WB (regDst=01, RegInData=00).
  - 0x09 sw: ALUimm=1, add. EXEC->MEM (DWrite=1, pc_write=1)->FETCH.
  - 0x10 br: PCSel=01, brType=000.
  - 0x11-0x16 conditional branch: PCSel=01, brType=ir_op[2:0] (z, nz, cy, ncy, s, ns).
  - 0x18 jal: PCSel=01, regDst=10, RegInData=10, writeEn=1.
  - 0x19 jr: PCSel=10.
  - All of 0x10-0x19 assert pc_write in EXEC, then go to FETCH.
  - 0x3F halt: go to HALT.
- WB: writeEn=1 and pc_write=1, then FETCH. PC and register file sample at the same edge, so jal writes the old IncrPC.
- Latency in cycles: ALU/shift 4, lw 5, sw 4, branch/jal/jr 3.
- Branch flags are those latched by the most recent flag_en instruction. Non-ALU instructions never disturb the flags.
- retired increments on every posedge where pc_write=1 outside RESET, wrapping at 2^RETIRE_W.
- HALT: halted=1, all other controls 0. Held until rst_n.

Decomposition:
- Shared package risc_ctrl_pkg holds:
  - state enum
  - opcode/fn constants
  - RegInData, regDst and PCSel encodings
  - brType codes
- One sub-module, ctrl_decoder: combinational (ir_op, ir_fn, state) -> control vector, plus a legal flag.
- Sequencer FSM and retired counter stay in the top.

Test Plan:
- Reset then add (op 0x00, fn 0x00): PCReset=1 for 1 cycle. writeEn=1 with regDst=00, RegInData=01 exactly in cycle 4. retired=1 after.
- lw (0x08): DRead=1 in cycle 3 only. WB in cycle 4 with regDst=01, RegInData=00, writeEn=1. Total 5 cycles.
- sw (0x09): DWrite=1 and pc_write=1 in cycle 3. writeEn never asserted.
- sub then bz (0x11): flag_en=1 in sub's EXEC only. bz drives brType=001, PCSel=01, pc_write=1 in its EXEC, total 3 cycles.
- jal (0x18): regDst=10, RegInData=10, writeEn=1, pc_write=1 in one cycle. Then jr (0x19): PCSel=10.
- op 0x3F -> halted=1 forever. op 0x00 with fn 0x05 -> halted=1, illegal=1. rst_n pulse mid-lw MEM -> no writeEn, back to RESET.
